// File: rtl/hs_sync_receiver.sv
// hs_sync_receiver: 4-phase dreq/dack receiver with dreq synchroniser, capture FIFO and valid/ready output; HS_TIMEOUT_EN adds a sticky WAIT_LOW timeout flag
module hs_sync_receiver #(
    parameter int data_width  = 3,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
`ifdef HS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dreq_in,
    input  logic [data_width-1:0] data_in,
    output logic                  dack_out,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    input  logic                  out_ready
`ifdef HS_TIMEOUT_EN
    , output logic                hs_timeout
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_LOW} state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  req_s, full, wr_en, rd_en, dack_q, dack_d;
    logic [PW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         count_q, count_d;
    logic [data_width-1:0] mem_q [DEPTH];

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign full      = count_q == FULL;
    assign out_valid = count_q != '0;
    assign rd_en     = out_valid && out_ready;
    assign out_data  = mem_q[rd_q];
    assign dack_out  = dack_q;
    assign count_d   = count_q + CW'(wr_en) - CW'(rd_en);

    // dreq_in synchroniser; the only place dreq_in is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], dreq_in};
    end

    // FSM state and registered acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dack_q  <= dack_d;
        end
    end

    // next state: capture only when the registered count says there is room
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = req_s && !full ? CAPTURE : IDLE;
            CAPTURE:  state_d = WAIT_LOW;
            WAIT_LOW: state_d = req_s ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // outputs: the IDLE->CAPTURE edge writes the word and raises dack together
    always_comb begin
        wr_en  = state_q == IDLE && state_d == CAPTURE;
        dack_d = state_d != IDLE;
    end

    // circular FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= data_in;
                wr_q        <= wr_q == LAST ? '0 : wr_q + 1'b1;
            end
            if (rd_en) rd_q <= rd_q == LAST ? '0 : rd_q + 1'b1;
            count_q <= count_d;
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          flag_q;

    assign tmo_d      = state_q != WAIT_LOW ? '0 : tmo_q == TMAX ? tmo_q : tmo_q + 1'b1;
    assign hs_timeout = flag_q;

    // WAIT_LOW dwell counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            flag_q <= flag_q | (tmo_d == TMAX);
        end
    end
`endif
endmodule

// File: tb/tb_hs_sync_receiver.sv
// tb_hs_sync_receiver: directed self-checking bench for hs_sync_receiver
module tb_hs_sync_receiver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       dreq_in;
    logic [2:0] data_in;
    logic       dack_out;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
`ifdef HS_TIMEOUT_EN
    logic       hs_timeout;
`endif

    int         total = 0;
    int         pass_cnt = 0;
    logic [2:0] got [$];
    int         valid_cycles = 0;
    int         run = 0;
    int         max_run = 0;

    always #5 clk = ~clk;

`ifdef HS_TIMEOUT_EN
    hs_sync_receiver #(.data_width(3), .DEPTH(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .dreq_in(dreq_in), .data_in(data_in),
        .dack_out(dack_out), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .hs_timeout(hs_timeout)
    );
`else
    hs_sync_receiver #(.data_width(3), .DEPTH(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .dreq_in(dreq_in), .data_in(data_in),
        .dack_out(dack_out), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready)
    );
`endif

    // one clock edge; logs words accepted on it and tracks out_valid run lengths
    task automatic tick;
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clk);
        #1;
        if (out_valid) begin
            valid_cycles++;
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
    endtask

    // edges until dack_out reaches lvl, bounded at 40
    task automatic wait_dack(input logic lvl, output int edges);
        edges = 0;
        while (dack_out !== lvl && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0; dreq_in = 1'b0; data_in = 3'd0; out_ready = 1'b0;
        #2;
        total++;
        if ({dack_out, out_valid, out_data} !== 5'b0) $display("FAIL reset_hold: got %b want 00000", {dack_out, out_valid, out_data});
        else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({dack_out, out_valid, out_data} !== 5'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL reset_idle: %0d nonzero cycles want 0", bad);
        else pass_cnt++;
`ifdef HS_TIMEOUT_EN
        total++;
        if (hs_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", hs_timeout);
        else pass_cnt++;
`endif
    endtask

    task automatic test_single;
        int e;
        data_in = 3'b101; dreq_in = 1'b1;
        wait_dack(1'b1, e);
        total++;
        if (e != 3) $display("FAIL single_ack_latency: got %0d edges want 3", e);
        else pass_cnt++;
        total++;
        if (out_valid !== 1'b1 || out_data !== 3'd5) $display("FAIL single_data: got v=%b d=%0d want v=1 d=5", out_valid, out_data);
        else pass_cnt++;
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        total++;
        if (e != 3) $display("FAIL single_release_latency: got %0d edges want 3", e);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 3'd5) $display("FAIL single_hold: got v=%b d=%0d want v=1 d=5", out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL single_drain: got v=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int e;
        int hi;
        got.delete();
        for (int w = 1; w <= 2; w++) begin
            data_in = 3'(w); dreq_in = 1'b1;
            wait_dack(1'b1, e);
            total++;
            if (e != 3) $display("FAIL bp_ack_word%0d: got %0d edges want 3", w, e);
            else pass_cnt++;
            dreq_in = 1'b0;
            wait_dack(1'b0, e);
        end
        data_in = 3'd3; dreq_in = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dack_out !== 1'b0) hi++;
        end
        total++;
        if (hi != 0) $display("FAIL bp_full_hold: dack high %0d cycles want 0", hi);
        else pass_cnt++;
        total++;
        if (out_data !== 3'd1) $display("FAIL bp_head: got %0d want 1", out_data);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total++;
        if (dack_out !== 1'b0 || out_data !== 3'd2) $display("FAIL bp_after_read: got dack=%b d=%0d want dack=0 d=2", dack_out, out_data);
        else pass_cnt++;
        tick();
        total++;
        if (dack_out !== 1'b1 || out_data !== 3'd3) $display("FAIL bp_late_ack: got dack=%b d=%0d want dack=1 d=3", dack_out, out_data);
        else pass_cnt++;
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        total++;
        if (e != 3) $display("FAIL bp_release3: got %0d edges want 3", e);
        else pass_cnt++;
        data_in = 3'd4; dreq_in = 1'b1;
        wait_dack(1'b1, e);
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        tick(); tick();
        out_ready = 1'b0;
        total++;
        if (got.size() != 4) $display("FAIL bp_count: got %0d words want 4", got.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 3'(i + 1)) $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int e;
        got.delete();
        valid_cycles = 0; run = 0; max_run = 0;
        out_ready = 1'b1;
        data_in = 3'd6; dreq_in = 1'b1;
        wait_dack(1'b1, e);
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        data_in = 3'd7; dreq_in = 1'b1;
        wait_dack(1'b1, e);
        total++;
        if (e != 3) $display("FAIL b2b_ack_latency: got %0d edges want 3", e);
        else pass_cnt++;
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        tick(); tick();
        out_ready = 1'b0;
        total++;
        if (got.size() != 2 || got[0] !== 3'd6 || got[1] !== 3'd7)
            $display("FAIL b2b_words: got %0d words first=%0d want 2 words 6,7", got.size(), got.size() > 0 ? got[0] : 3'd0);
        else pass_cnt++;
        total++;
        if (valid_cycles != 2) $display("FAIL b2b_valid_cycles: got %0d want 2", valid_cycles);
        else pass_cnt++;
        total++;
        if (max_run != 1) $display("FAIL b2b_valid_run: got %0d want 1", max_run);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int e;
        out_ready = 1'b0;
        data_in = 3'd2; dreq_in = 1'b1;
        wait_dack(1'b1, e);
        tick(); tick();
        total++;
        if (dack_out !== 1'b1 || out_valid !== 1'b1 || out_data !== 3'd2) $display("FAIL mid_pre: got dack=%b v=%b d=%0d want 1 1 2", dack_out, out_valid, out_data);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({dack_out, out_valid, out_data} !== 5'b0) $display("FAIL mid_async_reset: got %b want 00000", {dack_out, out_valid, out_data});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        wait_dack(1'b1, e);
        total++;
        if (e != 3) $display("FAIL mid_recapture_latency: got %0d edges want 3", e);
        else pass_cnt++;
        total++;
        if (out_valid !== 1'b1 || out_data !== 3'd2) $display("FAIL mid_recapture_data: got v=%b d=%0d want v=1 d=2", out_valid, out_data);
        else pass_cnt++;
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL mid_drain: got v=%b want 0 (single word)", out_valid);
        else pass_cnt++;
    endtask

`ifdef HS_TIMEOUT_EN
    task automatic test_timeout;
        int e;
        out_ready = 1'b1;
        data_in = 3'd1; dreq_in = 1'b1;
        wait_dack(1'b1, e);
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (hs_timeout !== 1'b0) $display("FAIL tmo_early: got %b want 0", hs_timeout);
        else pass_cnt++;
        tick();
        total++;
        if (hs_timeout !== 1'b1) $display("FAIL tmo_set: got %b want 1", hs_timeout);
        else pass_cnt++;
        dreq_in = 1'b0;
        wait_dack(1'b0, e);
        tick(); tick();
        total++;
        if (hs_timeout !== 1'b1 || dack_out !== 1'b0) $display("FAIL tmo_sticky: got tmo=%b dack=%b want 1 0", hs_timeout, dack_out);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef HS_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
